// File: rtl/temp_buf_pkg.sv
// Shared definitions for the systolic array temp buffer address generators.
// Used by both the write-side and the read-side (ag_temp_out) generators.
//   FEATURE_BITS : default bits per tile dimension
//   ADDR_W       : temp buffer address width, {row, col}
//   agto_state_t : read-side generator FSM states
package temp_buf_pkg;

  localparam int unsigned FEATURE_BITS = 4;
  localparam int unsigned ADDR_W       = 2 * FEATURE_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } agto_state_t;

endpackage

// File: rtl/ag_temp_out_if.sv
// Bus bundle between ag_temp_out, the temp buffer read port and the downstream consumer.
//   rd_en/rd_addr : read strobe and {row, col} address toward the temp buffer
//   rd_data       : buffer read data, returned a fixed latency after rd_en
//   out_valid/out_ready/out_data/out_last : valid/ready stream toward the consumer
// master = address generator side, slave = buffer + consumer side.
interface ag_temp_out_if #(
  parameter int unsigned ADDR_W = temp_buf_pkg::ADDR_W,
  parameter int unsigned DATA_W = 16
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/temp_out_fifo.sv
// Synchronous show-ahead FIFO for words returned from the temp buffer.
//   sys_clk, reset : clock, synchronous active-high reset
//   push/push_data : write side
//   pop/pop_data   : read side; pop_data is the head, valid whenever !empty
//   full/empty     : status
//   count          : current occupancy
// Pushing while full is a protocol error caught by an assertion; the word is dropped.
module temp_out_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  push_when_full_a: assert property (@(posedge sys_clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/ag_temp_out.sv
// Read-side address generator for the systolic array temp buffer.
// Drains a rows x cols tile: issues rd_en/rd_addr, absorbs the fixed buffer read latency
// with a tag shift register and returns words to the consumer through a small FIFO with
// full valid/ready backpressure.
//   sys_clk, reset           : clock, synchronous active-high reset
//   start                    : begin a drain (honoured in IDLE only)
//   cfg_rows_m1, cfg_cols_m1 : tile size minus one, latched at accepted start
//   cfg_transpose            : column-major traversal (only with TEMP_OUT_TRANSPOSE_EN)
//   busy, done               : run status; done pulses one cycle after the final beat
//   bus                      : read port and output stream (ag_temp_out_if.master)
// Build option: define TEMP_OUT_TRANSPOSE_EN to add the cfg_transpose port.
module ag_temp_out #(
  parameter int unsigned FEATURE_BITS = temp_buf_pkg::FEATURE_BITS,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [FEATURE_BITS-1:0] cfg_rows_m1,
  input  logic [FEATURE_BITS-1:0] cfg_cols_m1,
`ifdef TEMP_OUT_TRANSPOSE_EN
  input  logic                    cfg_transpose,
`endif
  output logic                    busy,
  output logic                    done,
  ag_temp_out_if.master           bus
);

  import temp_buf_pkg::*;

  localparam int unsigned FIFO_DEPTH = RD_LAT + 2;
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ElemW      = 2 * FEATURE_BITS + 1;

  agto_state_t             state_q, state_d;
  logic [FEATURE_BITS-1:0] rows_q, cols_q;
  logic [FEATURE_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [RD_LAT-1:0]       tag_q, tag_d;
  logic [ElemW-1:0]        push_cnt_q;
  logic [ElemW-1:0]        rows_n, cols_n, total_m1;
  logic [CntW-1:0]         inflight, fifo_count;
  logic                    fifo_full, fifo_empty;
  logic [DATA_W:0]         fifo_head;
  logic                    accept, credit, rd_en, push, pop;
  logic                    row_last, col_last, col_major;

`ifdef TEMP_OUT_TRANSPOSE_EN
  logic transpose_q;
  assign col_major = transpose_q;
`else
  assign col_major = 1'b0;
`endif

  assign accept   = (state_q == IDLE) & start;
  assign row_last = (row_q == rows_q);
  assign col_last = (col_q == cols_q);

  // Words already requested but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CntW'(tag_q[i]);
  end

  // Only reserve space against current occupancy; a pop this cycle frees space next cycle.
  // fifo_full is implied by the sum check and only kept as a safety net.
  assign credit = ~fifo_full &&
                  (({1'b0, inflight} + {1'b0, fifo_count}) < (CntW + 1)'(FIFO_DEPTH));
  assign rd_en  = (state_q == ISSUE) & credit;

  if (RD_LAT == 1) begin : g_tag_one
    assign tag_d = rd_en;
  end else begin : g_tag_many
    assign tag_d = {tag_q[RD_LAT-2:0], rd_en};
  end

  assign push = tag_q[RD_LAT-1];
  assign pop  = bus.out_valid & bus.out_ready;

  // Last element is identified by count of returned words, independent of traversal order.
  assign rows_n   = ElemW'(rows_q) + ElemW'(1);
  assign cols_n   = ElemW'(cols_q) + ElemW'(1);
  assign total_m1 = ElemW'(rows_n * cols_n) - ElemW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (rd_en) begin
          if (row_last && col_last) begin
            state_d = DRAIN;
          end else if (!col_major) begin
            if (col_last) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            if (row_last) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && fifo_head[DATA_W]) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      tag_q      <= '0;
      push_cnt_q <= '0;
`ifdef TEMP_OUT_TRANSPOSE_EN
      transpose_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tag_q   <= tag_d;
      if (accept) begin
        rows_q     <= cfg_rows_m1;
        cols_q     <= cfg_cols_m1;
        push_cnt_q <= '0;
`ifdef TEMP_OUT_TRANSPOSE_EN
        transpose_q <= cfg_transpose;
`endif
      end else if (push) begin
        push_cnt_q <= push_cnt_q + 1'b1;
      end
    end
  end

  temp_out_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_cnt_q == total_m1, bus.rd_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are forced to zero when idle so stale FIFO storage never shows.
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? {row_q, col_q} : '0;
  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign bus.out_last  = ~fifo_empty & fifo_head[DATA_W];

endmodule

// File: tb/tb_ag_temp_out.sv
module tb_ag_temp_out;

  localparam int unsigned FB         = 4;
  localparam int unsigned DW         = 16;
  localparam int unsigned RL         = 1;
  localparam int unsigned FIFO_DEPTH = RL + 2;
  localparam int unsigned NWORDS     = 1 << (2 * FB);

  logic          sys_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [FB-1:0] cfg_rows_m1 = '0;
  logic [FB-1:0] cfg_cols_m1 = '0;
`ifdef TEMP_OUT_TRANSPOSE_EN
  logic          cfg_transpose = 1'b0;
`endif
  logic          busy, done;

  ag_temp_out_if #(.ADDR_W(2 * FB), .DATA_W(DW)) bus ();

  ag_temp_out #(
    .FEATURE_BITS (FB),
    .DATA_W       (DW),
    .RD_LAT       (RL)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .start       (start),
    .cfg_rows_m1 (cfg_rows_m1),
    .cfg_cols_m1 (cfg_cols_m1),
`ifdef TEMP_OUT_TRANSPOSE_EN
    .cfg_transpose (cfg_transpose),
`endif
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, first_rd_rel = -1, done_rel = -1;
  int tile_rd = 0, tile_beats = 0, tile_last = 0, max_out = 0, cur_n = 0;
  int rd_total = 0, beat_total = 0, done_count = 0;
  int mode = 0;

  logic [DW-1:0]     mem [NWORDS];
  logic [DW-1:0]     pipe [RL];
  logic [2*FB-1:0]   exp_addr [$];
  logic [DW:0]       exp_out [$];
  logic              prev_stall = 1'b0, prev_last = 1'b0, hs;
  logic [DW-1:0]     prev_data = '0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Temp buffer model: word appears RL cycles after rd_en; garbage otherwise.
  always @(posedge sys_clk) begin
    pipe[0] <= bus.rd_en ? mem[bus.rd_addr] : DW'($urandom);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.rd_data = pipe[RL-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready pattern.
  initial forever begin
    @(posedge sys_clk);
    #1;
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = !(((cyc - start_cyc) >= 3) && ((cyc - start_cyc) <= 14));
    endcase
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge sys_clk);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      hs = bus.out_valid && bus.out_ready;
      if (prev_stall) begin
        check("stall valid held", bus.out_valid, 1);
        check("stall data held", bus.out_data, prev_data);
        check("stall last held", bus.out_last, prev_last);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.rd_en) begin
        rd_total++;
        tile_rd++;
        if (first_rd_rel < 0) first_rd_rel = cyc - start_cyc;
        check("rd_en expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) check("rd_addr", bus.rd_addr, exp_addr.pop_front());
      end
      if (hs) begin
        beat_total++;
        tile_beats++;
        if (bus.out_last) tile_last++;
        check("out beat expected", exp_out.size() != 0, 1);
        if (exp_out.size() != 0) check("out {last,data}", {bus.out_last, bus.out_data},
                                       exp_out.pop_front());
      end
      if (tile_rd - tile_beats > max_out) max_out = tile_rd - tile_beats;
      if (done) begin
        done_count++;
        done_rel = cyc - start_cyc;
      end
    end
  end

  // Reference: tile traversal from the rules, buffer contents from mem.
  task automatic launch(input int rm1, input int cm1, input bit tr);
    int n, idx;
    logic [FB-1:0] r, c;
    for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom);
    n   = (rm1 + 1) * (cm1 + 1);
    idx = 0;
    for (int o = 0; o <= (tr ? cm1 : rm1); o++) begin
      for (int i = 0; i <= (tr ? rm1 : cm1); i++) begin
        r = FB'(tr ? i : o);
        c = FB'(tr ? o : i);
        exp_addr.push_back({r, c});
        exp_out.push_back({idx == n - 1, mem[{r, c}]});
        idx++;
      end
    end
    @(posedge sys_clk);
    #1;
    cfg_rows_m1 = FB'(rm1);
    cfg_cols_m1 = FB'(cm1);
`ifdef TEMP_OUT_TRANSPOSE_EN
    cfg_transpose = tr;
`endif
    start        = 1'b1;
    start_cyc    = cyc;
    first_rd_rel = -1;
    done_rel     = -1;
    tile_rd      = 0;
    tile_beats   = 0;
    tile_last    = 0;
    max_out      = 0;
    cur_n        = n;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    @(negedge sys_clk);
    #1;
    check("busy after start", busy, 1);
  endtask

  task automatic finish_tile(input bit timed);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge sys_clk);
      #1;
      if (done) ok = 1'b1;
    end
    check("done seen", ok, 1);
    if (ok && timed) begin
      check("first rd_en cycle", first_rd_rel, 1);
      check("done cycle", done_rel, cur_n + RL + 2);
    end
    check("busy low in done cycle", busy, 0);
    check("addr queue drained", exp_addr.size(), 0);
    check("out queue drained", exp_out.size(), 0);
    check("one last beat", tile_last, 1);
    @(negedge sys_clk);
    #1;
    check("busy low after done", busy, 0);
    check("done single pulse", done, 0);
  endtask

  initial begin
    int dc0, b0, r0;
    bit ok;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset rd_en", bus.rd_en, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(posedge sys_clk);
    #1;
    reset = 1'b0;

    // Full tile, no backpressure.
    mode = 0;
    launch(15, 15, 0);
    finish_tile(1);

    // 2x3 row-major.
    launch(1, 2, 0);
    finish_tile(1);

    // Backpressure window.
    mode = 2;
    launch(3, 3, 0);
    finish_tile(0);
    check("max outstanding", max_out, FIFO_DEPTH);
    mode = 0;

    // Reset mid-ISSUE after five reads.
    launch(3, 3, 0);
    for (int i = 0; i < 50 && tile_rd < 5; i++) begin
      @(negedge sys_clk);
      #1;
    end
    check("reads before reset", tile_rd, 5);
    @(posedge sys_clk);
    #1;
    reset = 1'b1;
    dc0   = done_count;
    @(posedge sys_clk);
    #1;
    reset = 1'b0;
    exp_addr.delete();
    exp_out.delete();
    @(negedge sys_clk);
    #1;
    check("post-reset rd_en", bus.rd_en, 0);
    check("post-reset rd_addr", bus.rd_addr, 0);
    check("post-reset out_valid", bus.out_valid, 0);
    check("post-reset out_data", bus.out_data, 0);
    check("post-reset out_last", bus.out_last, 0);
    check("post-reset busy", busy, 0);
    check("post-reset done", done, 0);
    b0 = beat_total;
    r0 = rd_total;
    repeat (6) @(negedge sys_clk);
    #1;
    check("no beats after reset", beat_total - b0, 0);
    check("no reads after reset", rd_total - r0, 0);
    check("no done after abort", done_count - dc0, 0);
    launch(3, 3, 0);
    finish_tile(1);

    // start during ISSUE and in the DONE cycle is ignored.
    launch(1, 2, 0);
    @(posedge sys_clk);
    #1;
    cfg_rows_m1 = '0;
    cfg_cols_m1 = '0;
    start       = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge sys_clk);
      #1;
      if (bus.out_valid && bus.out_ready && bus.out_last) ok = 1'b1;
    end
    check("last beat seen", ok, 1);
    @(posedge sys_clk);
    #1;
    check("done while start pulsed", done, 1);
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge sys_clk);
    #1;
    check("no restart busy", busy, 0);
    check("reads of ignored-start tile", tile_rd, 6);
    check("beats of ignored-start tile", tile_beats, 6);
    check("queues empty", exp_addr.size() + exp_out.size(), 0);
    launch(0, 0, 0);
    finish_tile(1);
    check("1x1 single read", tile_rd, 1);

`ifdef TEMP_OUT_TRANSPOSE_EN
    launch(1, 2, 1);
    finish_tile(1);
`endif

    // Randomized tiles with random backpressure.
    mode = 1;
    for (int k = 0; k < 6; k++) begin
      bit tr;
      tr = 1'b0;
`ifdef TEMP_OUT_TRANSPOSE_EN
      tr = 1'($urandom_range(0, 1));
`endif
      launch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), tr);
      finish_tile(0);
    end
    mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ag_temp_out.md
Name: ag_temp_out

Overview:
Read-side address generator for the systolic array temp buffer. It drains a stored tile in order once the write side has filled it. On start it issues rd_en/rd_addr over a configurable rows x cols tile and absorbs the fixed buffer read latency. Returned words go to a downstream consumer (LSTM gate stage) over a valid/ready stream with full backpressure and no data loss.

Parameters:
FEATURE_BITS, 4, bits per tile dimension; rd_addr = {row, col}, 2*FEATURE_BITS wide
DATA_W, 16, temp buffer word width
RD_LAT, 1, buffer read latency in cycles (>=1)
FIFO_DEPTH, RD_LAT+2, internal return FIFO depth (derived, not overridden)

Ports:
sys_clk  in  1  systolic array clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins drain (sampled in IDLE only)
cfg_rows_m1  in  FEATURE_BITS  tile rows minus 1, latched at accepted start
cfg_cols_m1  in  FEATURE_BITS  tile cols minus 1, latched at accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final output handshake
rd_en  out  1  temp buffer read strobe
rd_addr  out  2*FEATURE_BITS  {row, col} read address
rd_data  in  DATA_W  buffer data, valid RD_LAT cycles after rd_en
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts
out_data  out  DATA_W  returned word (FIFO head)
out_last  out  1  marks final element of tile

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters/FIFO/latency tags cleared. Data in flight at reset is dropped. Reset mid-operation aborts with no done.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches cfg, clears row/col counters, next state ISSUE, busy=1 next cycle.
- ISSUE: when credit is available, rd_en=1 and rd_addr={row,col}. Col increments; at cfg_cols_m1 col wraps to 0 and row increments. Issuing (cfg_rows_m1, cfg_cols_m1) moves to DRAIN.
- Credit: issue only if inflight + fifo_count < FIFO_DEPTH, using current-cycle values. A same-cycle pop is not credited.
- inflight = number of set RD_LAT-deep tag shift-register stages.
- Latency: rd_en high in cycle k -> rd_data sampled at end of cycle k+RD_LAT and pushed to FIFO -> out_valid earliest in cycle k+RD_LAT+1.
- Throughput: out_ready held 1 gives one rd_en per cycle, no bubbles.
- Handshake: out_data/out_last stay stable while out_valid=1 and out_ready=0. Pop on out_valid & out_ready.
- out_last: high on the element whose index = (rows)*(cols)-1. It is tracked by an output counter, not by address.
- DRAIN: no issue. Transition to DONE on the handshake of the out_last element.
- DONE: done=1 and busy=0 for one cycle, then IDLE. start is ignored in ISSUE, DRAIN and DONE.
- Boundary cases:
  - 1x1 tile (both cfg=0): single rd_en, IDLE->ISSUE->DRAIN.
  - Full 2^FB x 2^FB tile: counters wrap without overflow; the element counter is 2*FEATURE_BITS+1 bits wide.
  - FIFO never overflows because credit guarantees it; push while full is an assertion failure.

Optional Feature:
- Macro TEMP_OUT_TRANSPOSE_EN.
- Defined: adds input cfg_transpose (1 bit, latched at start). When 1, traversal is column-major: row is the inner counter up to cfg_rows_m1 and col is outer; rd_addr remains {row,col}. out_last is unchanged (count-based).
- Undefined: port absent, row-major only.

Decomposition:
- Package temp_buf_pkg: FEATURE_BITS default, ADDR_W = 2*FEATURE_BITS, agto_state_t enum {IDLE, ISSUE, DRAIN, DONE}. This package is shared with the write-side address generator.
- One sub-module temp_out_fifo: synchronous show-ahead FIFO with params DATA_W+1 (data plus last) and FIFO_DEPTH, ports push/pop/full/empty/count, same clock and reset.

Test Plan:
- Full tile, out_ready=1, cfg 15/15, start at cycle 0:
  - rd_en cycles 1..256, rd_addr 0x00..0xFF in order.
  - out_data matches buffer model; out_last on the 256th beat.
  - done in cycle 259 with RD_LAT=1.
- cfg rows_m1=1, cols_m1=2:
  - addresses 0x00,0x01,0x02,0x10,0x11,0x12.
  - out_last only on the 6th beat; busy low after done.
- Backpressure, 4x4 tile, out_ready=0 for cycles 3..14:
  - rd_en stops with at most FIFO_DEPTH=3 words outstanding.
  - All 16 words delivered in order, no duplicates; out_data stable while stalled.
- Reset asserted for 1 cycle mid-ISSUE (after 5 reads):
  - next cycle all outputs 0, no done.
  - New start re-reads from 0x00 and late rd_data from the aborted run is not emitted.
- start pulsed during ISSUE and in the DONE cycle: ignored, with cfg and counters unchanged. A 1x1 tile then gives exactly one rd_en at 0x00 and one out_last beat.
- TEMP_OUT_TRANSPOSE_EN with cfg_transpose=1, 2x3 tile: addresses 0x00,0x10,0x01,0x11,0x02,0x12.
